cnn_sequencer: RTL and testbench

Control block for the single-image CNN inference datapath: conv, relu, pooling and fully connected stages. It streams one 32-bit pixel per handshake into the datapath's image buffer, then waits a fixed number of cycles for the combinational datapath to settle. It then scans the class scores one per cycle and reports the argmax class with a one-cycle `done` pulse. It sits between the host-side input stream and the `cnn` datapath top.

---
 rtl/cnn_ctrl_pkg.sv | 14 +
 rtl/argmax_tracker.sv | 33 +++
 rtl/cnn_sequencer.sv | 91 +++++++++
 tb/tb_cnn_sequencer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/cnn_ctrl_pkg.sv
// cnn_ctrl_pkg: shared state encoding, width defaults and width helper for the CNN sequencer
package cnn_ctrl_pkg;
  localparam int DATA_W_DEF = 32;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SETTLE = 3'd2,
    SCAN   = 3'd3,
    DONE   = 3'd4
  } state_t;
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/argmax_tracker.sv
// argmax_tracker: running signed argmax; best_* include the current input so the caller can latch the final winner on the last index
module argmax_tracker
  import cnn_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int SW     = 4
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              first,
  input  logic              valid,
  input  logic [SW-1:0]     idx,
  input  logic [DATA_W-1:0] score,
  output logic [SW-1:0]     best_idx,
  output logic [DATA_W-1:0] best_score
);
  logic [SW-1:0]     r_idx;
  logic [DATA_W-1:0] r_score;
  logic              take;
  // strict greater keeps the lowest index on ties
  assign take       = valid && (first || $signed(score) > $signed(r_score));
  assign best_idx   = take ? idx : r_idx;
  assign best_score = take ? score : r_score;
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_idx   <= '0;
      r_score <= '0;
    end else if (valid) begin
      r_idx   <= best_idx;
      r_score <= best_score;
    end
  end
endmodule

// File: rtl/cnn_sequencer.sv
// cnn_sequencer: streams one image into the CNN buffer, waits for the datapath to settle, then scans class scores for the argmax
module cnn_sequencer
  import cnn_ctrl_pkg::*;
#(
  parameter int  INPUT_SIZE    = 28,
  parameter int  NUM_CLASSES   = 10,
  parameter int  SETTLE_CYCLES = 4,
  parameter int  DATA_W        = DATA_W_DEF,
  localparam int NPIX          = INPUT_SIZE * INPUT_SIZE,
  localparam int AW            = width_of(NPIX),
  localparam int SW            = width_of(NUM_CLASSES)
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              pix_wr_en,
  output logic [AW-1:0]     pix_wr_addr,
  output logic [DATA_W-1:0] pix_wr_data,
  output logic [SW-1:0]     score_sel,
  input  logic [DATA_W-1:0] score,
  output logic              busy,
  output logic              done,
  output logic [SW-1:0]     class_id,
  output logic [DATA_W-1:0] class_score
);
  localparam int CW = width_of(SETTLE_CYCLES);
  state_t            st;
  logic [CW-1:0]     settle_cnt;
  logic [SW-1:0]     best_idx;
  logic [DATA_W-1:0] best_score;
  assign in_ready    = st == LOAD;
  assign busy        = st != IDLE;
  assign done        = st == DONE;
  assign pix_wr_en   = in_valid && in_ready && !abort;
  assign pix_wr_data = in_data;
  argmax_tracker #(.DATA_W(DATA_W), .SW(SW)) u_argmax (
    .clk        (clk),
    .rstb       (rstb),
    .first      (score_sel == '0),
    .valid      (st == SCAN && !abort),
    .idx        (score_sel),
    .score      (score),
    .best_idx   (best_idx),
    .best_score (best_score)
  );
  // pix_wr_addr doubles as the pixel counter; it parks on NPIX-1 after the last pixel
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      st          <= IDLE;
      pix_wr_addr <= '0;
      settle_cnt  <= '0;
      score_sel   <= '0;
      class_id    <= '0;
      class_score <= '0;
    end else if (abort) begin
      st        <= IDLE;
      score_sel <= '0;
    end else begin
      case (st)
        IDLE: if (start) begin
          st          <= LOAD;
          pix_wr_addr <= '0;
        end
        LOAD: if (in_valid) begin
          if (pix_wr_addr == AW'(NPIX - 1)) begin
            st         <= SETTLE;
            settle_cnt <= CW'(SETTLE_CYCLES - 1);
          end else begin
            pix_wr_addr <= pix_wr_addr + AW'(1);
          end
        end
        SETTLE: if (settle_cnt == '0) st <= SCAN;
                else settle_cnt <= settle_cnt - CW'(1);
        SCAN: if (score_sel == SW'(NUM_CLASSES - 1)) begin
          st          <= DONE;
          score_sel   <= '0;
          class_id    <= best_idx;
          class_score <= best_score;
        end else begin
          score_sel <= score_sel + SW'(1);
        end
        DONE:    st <= IDLE;
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cnn_sequencer.sv
// tb_cnn_sequencer: directed bench with write/result scoreboards for cnn_sequencer
module tb_cnn_sequencer;
  logic        clk = 0, rstb = 0, start = 0, abort = 0, in_valid = 0;
  logic [31:0] in_data = 0;
  logic        in_ready, pix_wr_en, busy, done;
  logic [9:0]  pix_wr_addr;
  logic [31:0] pix_wr_data, score, class_score;
  logic [3:0]  score_sel, class_id;
  logic signed [31:0] score_tbl [16];
  logic [41:0] wq[$];
  logic [35:0] rq[$];
  int tests = 0, fails = 0, cyc = 0, pix = 0, done_seen = 0, writes = 0, last_hs = 0, w0 = 0;

  assign score = score_tbl[score_sel];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cnn_sequencer dut (
    .clk(clk), .rstb(rstb), .start(start), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .pix_wr_en(pix_wr_en), .pix_wr_addr(pix_wr_addr), .pix_wr_data(pix_wr_data),
    .score_sel(score_sel), .score(score), .busy(busy), .done(done),
    .class_id(class_id), .class_score(class_score)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard consumer: writes and completion results
  always @(negedge clk) begin
    logic [41:0] e;
    logic [35:0] r;
    #2;
    if (pix_wr_en === 1'b1) begin
      writes++;
      last_hs = cyc;
      if (wq.size() == 0) check("spurious_write", 64'(wq.size()), 64'd1);
      else begin
        e = wq.pop_front();
        check("write", {22'b0, pix_wr_addr, pix_wr_data}, {22'b0, e});
      end
    end
    if (done === 1'b1) begin
      done_seen++;
      check("done_latency", 64'(cyc - last_hs), 64'd15);
      if (rq.size() == 0) check("spurious_done", 64'(rq.size()), 64'd1);
      else begin
        r = rq.pop_front();
        check("class", {28'b0, class_id, class_score}, {28'b0, r});
      end
    end
  end

  task automatic set_scores(input int s[10]);
    foreach (s[i]) score_tbl[i] = s[i];
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_wr_en"}, pix_wr_en, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_addr"}, pix_wr_addr, 0);
    check({tag, "_sel"}, score_sel, 0);
    check({tag, "_class_id"}, class_id, 0);
    check({tag, "_class_score"}, class_score, 0);
  endtask

  task automatic begin_run();
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    pix = 0;
    w0 = writes;
    check("busy_after_start", busy, 1);
  endtask

  task automatic load(input int n, input bit bp);
    int k = 0;
    for (int g = 0; k < n && g < 4000; g++) begin
      in_valid = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = bp ? $urandom : 32'(pix);
      #1 check("in_ready_load", in_ready, 1);
      if (in_valid) begin
        wq.push_back({10'(pix), in_data});
        pix++;
        k++;
      end
      @(negedge clk);
    end
    in_valid = 0;
  endtask

  task automatic finish_run();
    int d0;
    in_valid = 1;
    #1 check("ready_low_after_last", in_ready, 0);
    check("no_extra_write", pix_wr_en, 0);
    in_valid = 0;
    d0 = done_seen;
    for (int i = 0; i < 40 && done_seen == d0; i++) @(negedge clk);
    @(negedge clk) #3;
    check("done_count", 64'(done_seen), 64'(d0 + 1));
    check("write_count", 64'(writes - w0), 64'd784);
    check("done_one_cycle", done, 0);
    check("idle_after_done", busy, 0);
  endtask

  initial begin
    int d1;
    foreach (score_tbl[i]) score_tbl[i] = 0;
    #1 reset_checks("por");
    repeat (2) @(negedge clk);
    rstb = 1;
    // basic run, ties resolve to lowest index
    set_scores('{5, -3, 9, 9, 2, 0, -8, 1, 9, 4});
    rq.push_back({4'd2, 32'd9});
    begin_run();
    load(784, 0);
    finish_run();
    // all negative with backpressure
    set_scores('{-10, -2, -7, -3, -9, -5, -4, -6, -8, -20});
    rq.push_back({4'd1, 32'hFFFF_FFFE});
    begin_run();
    load(784, 1);
    finish_run();
    // winner at the last index
    set_scores('{-5, -2, 1, 4, 7, 10, 13, 16, 19, 22});
    rq.push_back({4'd9, 32'd22});
    begin_run();
    load(784, 0);
    finish_run();
    // abort during load at pixel 300
    begin_run();
    load(300, 0);
    in_valid = 1;
    abort = 1;
    #1 check("abort_write_suppressed", pix_wr_en, 0);
    @(negedge clk) abort = 0;
    in_valid = 0;
    check("abort_load_idle", busy, 0);
    check("abort_load_ready", in_ready, 0);
    check("abort_load_class_id", class_id, 9);
    check("abort_load_class_score", class_score, 22);
    // abort during scan at index 5
    set_scores('{50, 50, 50, 50, 50, 50, 50, 51, 50, 50});
    d1 = done_seen;
    begin_run();
    load(784, 0);
    repeat (9) @(negedge clk);
    check("scan_index_before_abort", score_sel, 5);
    abort = 1;
    @(negedge clk) abort = 0;
    check("abort_scan_idle", busy, 0);
    check("abort_scan_done", done, 0);
    check("abort_scan_class_id", class_id, 9);
    check("abort_scan_class_score", class_score, 22);
    repeat (20) @(negedge clk);
    check("no_done_after_abort", 64'(done_seen), 64'(d1));
    // fresh run after aborts
    rq.push_back({4'd7, 32'd51});
    begin_run();
    load(784, 1);
    finish_run();
    // asynchronous reset in the middle of load
    begin_run();
    load(100, 0);
    rstb = 0;
    #1 reset_checks("midreset");
    @(negedge clk) rstb = 1;
    // start pulses during scan and in the done cycle are ignored
    set_scores('{3, 8, -1, 8, 0, 2, 6, 7, 5, 4});
    rq.push_back({4'd1, 32'd8});
    begin_run();
    load(784, 0);
    repeat (7) @(negedge clk);
    start = 1;
    @(negedge clk) start = 0;
    repeat (6) @(negedge clk);
    #1 check("done_at_t15", done, 1);
    start = 1;
    @(negedge clk) start = 0;
    check("start_in_done_idle", busy, 0);
    @(negedge clk);
    check("start_in_done_ignored", busy, 0);
    check("start_in_scan_ready", in_ready, 0);
    repeat (3) @(negedge clk);
    check("write_queue_empty", 64'(wq.size()), 64'd0);
    check("result_queue_empty", 64'(rq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
